// File: rtl/general_pack.sv
// Shared types and helpers for the Avalon-ST length limiter and its skid buffer.
package general_pack;

  typedef enum logic [1:0] {
    BETWEEN_MSG = 2'd0,
    IN_MSG      = 2'd1,
    DROPPING    = 2'd2
  } limiter_sm_t;

  // Ceiling log2 with a floor of 1 bit, usable in constant expressions.
  function automatic int log2up_func(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data, framing and valid/ready handshake.
interface avalon_st_if
  import general_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  logic [8*DATA_WIDTH_IN_BYTES-1:0]              data;
  logic [log2up_func(DATA_WIDTH_IN_BYTES)-1:0]   empty;
  logic                                          sop;
  logic                                          eop;
  logic                                          valid;
  logic                                          rdy;

  modport master (output data, empty, sop, eop, valid, input rdy);
  modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/avalon_skid_buffer.sv
// Two-entry output buffer with a registered ready that never looks at out_rdy_i
// combinationally: ready is high whenever at most one entry is held.
module avalon_skid_buffer
  import general_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid_i,
  input  logic                                        in_sop_i,
  input  logic                                        in_eop_i,
  input  logic [log2up_func(DATA_WIDTH_IN_BYTES)-1:0] in_empty_i,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0]            in_data_i,
  output logic                                        in_rdy_o,
  output logic                                        out_valid_o,
  output logic                                        out_sop_o,
  output logic                                        out_eop_o,
  output logic [log2up_func(DATA_WIDTH_IN_BYTES)-1:0] out_empty_o,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0]            out_data_o,
  input  logic                                        out_rdy_i
);
  localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES);
  localparam int PW = 8*DATA_WIDTH_IN_BYTES + EW + 2;

  logic [PW-1:0] head_q, head_d, skid_q, skid_d, in_payload_s;
  logic          head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic          rdy_q, rdy_d, pop_s;

  assign in_payload_s = {in_sop_i, in_eop_i, in_empty_i, in_data_i};
  assign pop_s        = head_vld_q & out_rdy_i;

  // Pop first so a simultaneous push lands in whichever slot is then free.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop_s) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
      end
    end else begin
      head_vld_d = head_vld_q;
    end
    if (in_valid_i) begin
      if (head_vld_d) begin
        skid_d     = in_payload_s;
        skid_vld_d = 1'b1;
      end else begin
        head_d     = in_payload_s;
        head_vld_d = 1'b1;
      end
    end else begin
      skid_d = skid_q;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q     <= {PW{1'b0}};
      skid_q     <= {PW{1'b0}};
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign {out_sop_o, out_eop_o, out_empty_o, out_data_o} = head_q;
  assign out_valid_o = head_vld_q;
  assign in_rdy_o    = rdy_q;
endmodule

// File: rtl/avalon_length_limiter.sv
// Cuts Avalon-ST messages to MAX_MSG_BYTES, discarding the tail until eop.
// Optional length statistics ports: define AVALON_LENGTH_LIMITER_STATS_EN.
module avalon_length_limiter
  import general_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_MSG_BYTES       = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  avalon_st_if.slave                            msg_in,
  avalon_st_if.master                           msg_out,
  output logic                                  truncated_indi,
  output logic                                  dropped_beat_indi
`ifdef AVALON_LENGTH_LIMITER_STATS_EN
  ,
  output logic [log2up_func(MAX_MSG_BYTES):0]   msg_len,
  output logic                                  msg_len_vld
`endif
);
  localparam int CW = log2up_func(MAX_MSG_BYTES) + 1;
  localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES);
  localparam logic [CW-1:0] BEAT_FULL = CW'(DATA_WIDTH_IN_BYTES);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_MSG_BYTES);

  limiter_sm_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, beat_bytes_s;
  logic          acc_s, fwd_s, force_eop_s, rdy_s;
  logic          trunc_q, trunc_d, drop_q, drop_d;

  assign acc_s      = msg_in.valid & rdy_s;
  assign msg_in.rdy = rdy_s;

  always_comb begin
    if (msg_in.eop) begin
      beat_bytes_s = BEAT_FULL - {{(CW-EW){1'b0}}, msg_in.empty};
    end else begin
      beat_bytes_s = BEAT_FULL;
    end
  end

  // The counter tops out at MAX - beat width before the cut, so it cannot wrap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fwd_s       = 1'b0;
    force_eop_s = 1'b0;
    trunc_d     = 1'b0;
    drop_d      = 1'b0;
    case (state_q)
      BETWEEN_MSG: begin
        if (acc_s) begin
          fwd_s = 1'b1;
          if (msg_in.sop && !msg_in.eop) begin
            if (BEAT_FULL == MAX_C) begin
              force_eop_s = 1'b1;
              trunc_d     = 1'b1;
              state_d     = DROPPING;
            end else begin
              state_d = IN_MSG;
              cnt_d   = beat_bytes_s;
            end
          end else begin
            cnt_d = {CW{1'b0}};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      IN_MSG: begin
        if (acc_s) begin
          fwd_s = 1'b1;
          if (msg_in.eop) begin
            state_d = BETWEEN_MSG;
            cnt_d   = {CW{1'b0}};
          end else if (cnt_q + BEAT_FULL == MAX_C) begin
            force_eop_s = 1'b1;
            trunc_d     = 1'b1;
            state_d     = DROPPING;
            cnt_d       = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + BEAT_FULL;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DROPPING: begin
        if (acc_s) begin
          drop_d = 1'b1;
          if (msg_in.eop) begin
            state_d = BETWEEN_MSG;
          end else begin
            state_d = DROPPING;
          end
        end else begin
          drop_d = 1'b0;
        end
      end
      default: begin
        state_d = BETWEEN_MSG;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BETWEEN_MSG;
      cnt_q   <= {CW{1'b0}};
      trunc_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
    end
  end

  assign truncated_indi    = trunc_q;
  assign dropped_beat_indi = drop_q;

  avalon_skid_buffer #(
    .DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (acc_s & fwd_s),
    .in_sop_i   (msg_in.sop),
    .in_eop_i   (msg_in.eop | force_eop_s),
    .in_empty_i (force_eop_s ? {EW{1'b0}} : msg_in.empty),
    .in_data_i  (msg_in.data),
    .in_rdy_o   (rdy_s),
    .out_valid_o(msg_out.valid),
    .out_sop_o  (msg_out.sop),
    .out_eop_o  (msg_out.eop),
    .out_empty_o(msg_out.empty),
    .out_data_o (msg_out.data),
    .out_rdy_i  (msg_out.rdy)
  );

`ifdef AVALON_LENGTH_LIMITER_STATS_EN
  localparam int LEN_SAT_I = 2*MAX_MSG_BYTES - 1;
  localparam logic [CW:0] LEN_SAT = LEN_SAT_I[CW:0];

  logic [CW-1:0] len_acc_q, len_acc_d, len_q, len_d;
  logic [CW:0]   len_raw_s, len_sum_s;
  logic          len_vld_q, len_vld_d;

  // Counts every accepted beat, including discarded ones, saturating at 2*MAX-1.
  always_comb begin
    len_acc_d = len_acc_q;
    len_d     = len_q;
    len_vld_d = 1'b0;
    len_raw_s = {1'b0, (msg_in.sop ? {CW{1'b0}} : len_acc_q)} + {1'b0, beat_bytes_s};
    len_sum_s = (len_raw_s > LEN_SAT) ? LEN_SAT : len_raw_s;
    if (acc_s) begin
      if (msg_in.eop) begin
        len_d     = len_sum_s[CW-1:0];
        len_vld_d = 1'b1;
        len_acc_d = {CW{1'b0}};
      end else begin
        len_acc_d = len_sum_s[CW-1:0];
      end
    end else begin
      len_acc_d = len_acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_acc_q <= {CW{1'b0}};
      len_q     <= {CW{1'b0}};
      len_vld_q <= 1'b0;
    end else begin
      len_acc_q <= len_acc_d;
      len_q     <= len_d;
      len_vld_q <= len_vld_d;
    end
  end

  assign msg_len     = len_q;
  assign msg_len_vld = len_vld_q;
`endif
endmodule

// File: tb/tb_avalon_length_limiter.sv
// Directed bench for avalon_length_limiter with 16-byte beats and a 64-byte limit.
module tb_avalon_length_limiter;
  localparam int DW = 16;
  localparam int MAXB = 64;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) in_if();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) out_if();

  logic trunc, dropped;
  logic tog_en = 1'b0;
  logic tog_q = 1'b0;
  logic rdy_force = 1'b1;
`ifdef AVALON_LENGTH_LIMITER_STATS_EN
  logic [CW-1:0] msg_len;
  logic          msg_len_vld;
`endif

  avalon_length_limiter #(.DATA_WIDTH_IN_BYTES(DW), .MAX_MSG_BYTES(MAXB)) dut (
    .clk              (clk),
    .rst              (rst),
    .msg_in           (in_if),
    .msg_out          (out_if),
    .truncated_indi   (trunc),
    .dropped_beat_indi(dropped)
`ifdef AVALON_LENGTH_LIMITER_STATS_EN
    ,
    .msg_len          (msg_len),
    .msg_len_vld      (msg_len_vld)
`endif
  );

  assign out_if.rdy = tog_en ? tog_q : rdy_force;
  always @(posedge clk) tog_q <= ~tog_q;

  logic [133:0] out_mem [0:63];
  int out_n = 0, trunc_tot = 0, drop_tot = 0, len_tot = 0;
  logic [CW-1:0] len_last = '0;

  // Record output handshakes and indication pulses away from the active edge.
  always @(negedge clk) begin
    if (out_if.valid && out_if.rdy && out_n < 64) begin
      out_mem[out_n] <= {out_if.sop, out_if.eop, out_if.empty, out_if.data};
      out_n <= out_n + 1;
    end
    if (trunc) trunc_tot <= trunc_tot + 1;
    if (dropped) drop_tot <= drop_tot + 1;
`ifdef AVALON_LENGTH_LIMITER_STATS_EN
    if (msg_len_vld) begin
      len_tot  <= len_tot + 1;
      len_last <= msg_len;
    end
`endif
  end

  int vec = 0, errs = 0;

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [133:0] bt(input logic s, input logic e, input logic [3:0] em,
                                      input logic [127:0] d);
    return {s, e, em, d};
  endfunction

  function automatic logic [127:0] dat(input logic [7:0] id, input logic [7:0] ix);
    return {{14{8'h5A}}, id, ix};
  endfunction

  function automatic logic [133:0] cur();
    return {out_if.sop, out_if.eop, out_if.empty, out_if.data};
  endfunction

  task automatic send(input logic [133:0] b);
    logic acc;
    {in_if.sop, in_if.eop, in_if.empty, in_if.data} = b;
    in_if.valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_if.rdy;
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    chk("beat_accepted", 134'(acc), 134'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (out_if.valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_timeout", 134'(n < 60), 134'(1));
  endtask

  initial begin
    int base, t0, d0, l0, nbytes, k, len_b;
    logic e;
    logic [3:0] em;
    logic [133:0] ex [0:6];

    in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
    in_if.empty = 4'd0; in_if.data = 128'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 134'(out_if.valid), 134'(0));
    chk("rst_in_rdy", 134'(in_if.rdy), 134'(0));
    chk("rst_trunc", 134'(trunc), 134'(0));
    chk("rst_dropped", 134'(dropped), 134'(0));
    chk("rst_out_fields", cur(), 134'(0));
    rst = 1'b1;
    chk("rdy_before_edge", 134'(in_if.rdy), 134'(0));
    @(posedge clk);
    #1;
    chk("rdy_first_edge", 134'(in_if.rdy), 134'(1));

    // A: 3 beats, last empty 5 -> 43 bytes
    base = out_n; t0 = trunc_tot; d0 = drop_tot;
    ex[0] = bt(1'b1, 1'b0, 4'd0, dat(8'hA0, 8'd0));
    ex[1] = bt(1'b0, 1'b0, 4'd0, dat(8'hA0, 8'd1));
    ex[2] = bt(1'b0, 1'b1, 4'd5, dat(8'hA0, 8'd2));
    chk("A_idle_valid", 134'(out_if.valid), 134'(0));
    send(ex[0]);
    chk("A_latency_valid", 134'(out_if.valid), 134'(1));
    chk("A_latency_beat", cur(), ex[0]);
    send(ex[1]);
    send(ex[2]);
    drain();
    chk("A_count", 134'(out_n - base), 134'(3));
    nbytes = 0;
    for (int i = 0; i < 3; i++) begin
      chk("A_beat", out_mem[base+i], ex[i]);
      nbytes += out_mem[base+i][132] ? (16 - int'(out_mem[base+i][131:128])) : 16;
    end
    chk("A_bytes", 134'(nbytes), 134'(43));
    chk("A_trunc", 134'(trunc_tot - t0), 134'(0));
    chk("A_drop", 134'(drop_tot - d0), 134'(0));

    // B: exactly 64 bytes with natural eop
    base = out_n; t0 = trunc_tot;
    for (int i = 0; i < 4; i++) begin
      ex[i] = bt(i == 0, i == 3, 4'd0, dat(8'hB0, 8'(i)));
      send(ex[i]);
    end
    drain();
    chk("B_count", 134'(out_n - base), 134'(4));
    for (int i = 0; i < 4; i++) chk("B_beat", out_mem[base+i], ex[i]);
    chk("B_trunc", 134'(trunc_tot - t0), 134'(0));

    // C: 7 beats -> 4 out, 4th forced eop with empty 0, 3 dropped
    base = out_n; t0 = trunc_tot; d0 = drop_tot; l0 = len_tot;
    for (int i = 0; i < 7; i++) begin
      send(bt(i == 0, i == 6, (i == 3) ? 4'd7 : 4'd0, dat(8'hC0, 8'(i))));
    end
    drain();
    chk("C_count", 134'(out_n - base), 134'(4));
    chk("C_beat0", out_mem[base+0], bt(1'b1, 1'b0, 4'd0, dat(8'hC0, 8'd0)));
    chk("C_beat1", out_mem[base+1], bt(1'b0, 1'b0, 4'd0, dat(8'hC0, 8'd1)));
    chk("C_beat2", out_mem[base+2], bt(1'b0, 1'b0, 4'd0, dat(8'hC0, 8'd2)));
    chk("C_beat3_cut", out_mem[base+3], bt(1'b0, 1'b1, 4'd0, dat(8'hC0, 8'd3)));
    chk("C_trunc", 134'(trunc_tot - t0), 134'(1));
    chk("C_drop", 134'(drop_tot - d0), 134'(3));
`ifdef AVALON_LENGTH_LIMITER_STATS_EN
    chk("C_len_pulses", 134'(len_tot - l0), 134'(1));
    chk("C_len_value", 134'(len_last), 134'(112));
`endif

    // D: single sop+eop beat passes unchanged
    base = out_n; t0 = trunc_tot;
    ex[0] = bt(1'b1, 1'b1, 4'd9, dat(8'hD0, 8'd0));
    send(ex[0]);
    drain();
    chk("D_count", 134'(out_n - base), 134'(1));
    chk("D_beat", out_mem[base], ex[0]);
    chk("D_trunc", 134'(trunc_tot - t0), 134'(0));

    // E: 6 back-to-back messages of 1..6 beats with output ready toggling
    base = out_n; t0 = trunc_tot; d0 = drop_tot;
    tog_en = 1'b1;
    for (int m = 0; m < 6; m++) begin
      for (int b = 0; b <= m; b++) begin
        send(bt(b == 0, b == m, (b == m) ? 4'(m) : 4'd0, dat(8'(8'hE0 + m), 8'(b))));
      end
    end
    drain();
    tog_en = 1'b0;
    chk("E_count", 134'(out_n - base), 134'(18));
    k = 0;
    for (int m = 0; m < 6; m++) begin
      len_b = (m + 1 > 4) ? 4 : m + 1;
      for (int b = 0; b < len_b; b++) begin
        e  = (b == m) || (b == 3 && m >= 4);
        em = (b == m) ? 4'(m) : 4'd0;
        chk("E_beat", out_mem[base+k], bt(b == 0, e, em, dat(8'(8'hE0 + m), 8'(b))));
        k++;
      end
    end
    chk("E_trunc", 134'(trunc_tot - t0), 134'(2));
    chk("E_drop", 134'(drop_tot - d0), 134'(3));

    // F: fill buffer with output stalled; ready must not follow out rdy combinationally
    rdy_force = 1'b0;
    ex[0] = bt(1'b1, 1'b0, 4'd0, dat(8'hF0, 8'd0));
    ex[1] = bt(1'b0, 1'b1, 4'd0, dat(8'hF0, 8'd1));
    send(ex[0]);
    send(ex[1]);
    chk("F_full_rdy", 134'(in_if.rdy), 134'(0));
    chk("F_head", cur(), ex[0]);
    @(posedge clk);
    #1;
    chk("F_hold_valid", 134'(out_if.valid), 134'(1));
    chk("F_hold_beat", cur(), ex[0]);
    @(negedge clk);
    #1;
    rdy_force = 1'b1;
    #1;
    chk("F_rdy_no_comb", 134'(in_if.rdy), 134'(0));
    @(posedge clk);
    #1;
    chk("F_rdy_rise", 134'(in_if.rdy), 134'(1));
    chk("F_second", cur(), ex[1]);
    drain();

    // G: reset mid-message, then new messages only
    send(bt(1'b1, 1'b0, 4'd0, dat(8'h60, 8'd0)));
    send(bt(1'b0, 1'b0, 4'd0, dat(8'h60, 8'd1)));
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("G_valid_after_rst", 134'(out_if.valid), 134'(0));
    chk("G_rdy_after_rst", 134'(in_if.rdy), 134'(0));
    base = out_n; t0 = trunc_tot;
    ex[0] = bt(1'b1, 1'b1, 4'd2, dat(8'h61, 8'd0));
    send(ex[0]);
    drain();
    chk("G_count", 134'(out_n - base), 134'(1));
    chk("G_beat", out_mem[base], ex[0]);
    base = out_n;
    for (int i = 0; i < 4; i++) begin
      ex[i] = bt(i == 0, i == 3, 4'd0, dat(8'h62, 8'(i)));
      send(ex[i]);
    end
    drain();
    chk("G_after_count", 134'(out_n - base), 134'(4));
    chk("G_after_last", out_mem[base+3], ex[3]);
    chk("G_trunc", 134'(trunc_tot - t0), 134'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
